// File: rtl/maxpool2x2_stream.sv
// 2x2/stride-2 max-pooling engine: captures a flattened feature map on start and
// streams one pooled value per cycle with optional signed compare and fused ReLU.
module maxpool2x2_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 14,
    parameter int IMG_H  = 14,
    parameter int SIGNED = 0,
    parameter int RELU   = 0,
    localparam int OUT_W = IMG_W / 2,
    localparam int OUT_H = IMG_H / 2,
    localparam int N_OUT = OUT_W * OUT_H,
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [IMG_W*IMG_H*DATA_W-1:0]   frame,
    output logic                            busy,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic [IDX_W-1:0]                out_idx,
    output logic                            out_last,
    output logic                            done,
    output logic [1:0]                      dbg_state
);

    // out_valid/out_ready: a value transfers on each rising edge where both are high.
    // Once out_valid rises, out_data/out_idx/out_last hold until that transfer or abort.

    localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]                    state;
    logic [IMG_W*IMG_H*DATA_W-1:0] cap;
    logic [RW-1:0]                 win_row;
    logic [RW-1:0]                 sel_row;
    logic [CW-1:0]                 win_col;
    logic [CW-1:0]                 sel_col;
    logic [DATA_W-1:0]             p0, p1, p2, p3;
    logic [DATA_W-1:0]             m01, m23, m_all;
    logic [DATA_W-1:0]             win_max;
    logic                          handshake;
    logic [IDX_W-1:0]              idx_next;

    function automatic logic [DATA_W-1:0] pixel(input logic [IMG_W*IMG_H*DATA_W-1:0] img,
                                                input int r, input int c);
        return img[(r * IMG_W + c) * DATA_W +: DATA_W];
    endfunction

    function automatic logic greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;
    assign handshake = out_valid && out_ready;
    assign idx_next  = out_idx + IDX_W'(1);

    // The window about to be presented: window 0 in LOAD, otherwise the successor.
    always_comb begin
        sel_row = win_row;
        sel_col = win_col;
        if (state == S_LOAD) begin
            sel_row = '0;
            sel_col = '0;
        end else if (int'(win_col) == OUT_W - 1) begin
            sel_row = win_row + RW'(1);
            sel_col = '0;
        end else begin
            sel_col = win_col + CW'(1);
        end
    end

    always_comb begin
        p0    = pixel(cap, 2 * int'(sel_row),     2 * int'(sel_col));
        p1    = pixel(cap, 2 * int'(sel_row),     2 * int'(sel_col) + 1);
        p2    = pixel(cap, 2 * int'(sel_row) + 1, 2 * int'(sel_col));
        p3    = pixel(cap, 2 * int'(sel_row) + 1, 2 * int'(sel_col) + 1);
        m01   = greater(p1, p0) ? p1 : p0;
        m23   = greater(p3, p2) ? p3 : p2;
        m_all = greater(m23, m01) ? m23 : m01;
        win_max = m_all;
        if ((SIGNED != 0) && (RELU != 0) && m_all[DATA_W-1]) win_max = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cap       <= '0;
            win_row   <= '0;
            win_col   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            cap   <= frame;
                            state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        out_data  <= win_max;
                        out_idx   <= '0;
                        win_row   <= '0;
                        win_col   <= '0;
                        out_valid <= 1'b1;
                        out_last  <= (N_OUT == 1);
                        state     <= S_RUN;
                    end
                    S_RUN: begin
                        if (handshake) begin
                            if (out_idx != LAST_IDX) begin
                                out_idx  <= idx_next;
                                out_data <= win_max;
                                win_row  <= sel_row;
                                win_col  <= sel_col;
                                out_last <= (idx_next == LAST_IDX);
                            end else begin
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                done      <= 1'b1;
                                state     <= S_IDLE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: default 14x14 unsigned instance plus
// signed/ReLU instances and a 5x3 odd-size instance.
module tb_maxpool2x2_stream;

    localparam int DW   = 8;
    localparam int IW   = 14;
    localparam int IH   = 14;
    localparam int NPIX = IW * IH;
    localparam int NOUT = 49;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // default unsigned instance
    logic                 start     = 1'b0;
    logic                 abort     = 1'b0;
    logic                 out_ready = 1'b1;
    logic [NPIX*DW-1:0]   frame     = '0;
    logic                 busy, out_valid, out_last, done;
    logic [7:0]           out_data;
    logic [5:0]           out_idx;
    logic [1:0]           dbg_state;

    // signed instances (RELU off / on) sharing one frame and start
    logic                 start_s = 1'b0;
    logic [NPIX*DW-1:0]   frame_s = '0;
    logic                 busy_s, valid_s, last_s, done_s;
    logic [7:0]           data_s;
    logic [5:0]           idx_s;
    logic [1:0]           dbg_s;
    logic                 busy_r, valid_r, last_r, done_r;
    logic [7:0]           data_r;
    logic [5:0]           idx_r;
    logic [1:0]           dbg_r;

    // 5x3 instance
    logic                 start_m = 1'b0;
    logic [5*3*DW-1:0]    frame_m = '0;
    logic                 busy_m, valid_m, last_m, done_m;
    logic [7:0]           data_m;
    logic [0:0]           idx_m;
    logic [1:0]           dbg_m;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] exp_q[$];
    logic [7:0]    got_data[NOUT];
    int            n_acc, acc_cyc, done_cyc;

    maxpool2x2_stream dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frame(frame),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .done(done), .dbg_state(dbg_state)
    );

    maxpool2x2_stream #(.SIGNED(1), .RELU(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .abort(1'b0), .frame(frame_s),
        .busy(busy_s), .out_valid(valid_s), .out_ready(1'b1), .out_data(data_s),
        .out_idx(idx_s), .out_last(last_s), .done(done_s), .dbg_state(dbg_s)
    );

    maxpool2x2_stream #(.SIGNED(1), .RELU(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .start(start_s), .abort(1'b0), .frame(frame_s),
        .busy(busy_r), .out_valid(valid_r), .out_ready(1'b1), .out_data(data_r),
        .out_idx(idx_r), .out_last(last_r), .done(done_r), .dbg_state(dbg_r)
    );

    maxpool2x2_stream #(.IMG_W(5), .IMG_H(3)) dut_m (
        .clk(clk), .rst_n(rst_n), .start(start_m), .abort(1'b0), .frame(frame_m),
        .busy(busy_m), .out_valid(valid_m), .out_ready(1'b1), .out_data(data_m),
        .out_idx(idx_m), .out_last(last_m), .done(done_m), .dbg_state(dbg_m)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_valid"},     out_valid, 0);
        check({tag, "_data"},      out_data,  0);
        check({tag, "_idx"},       out_idx,   0);
        check({tag, "_last"},      out_last,  0);
        check({tag, "_done"},      done,      0);
        check({tag, "_dbg_state"}, dbg_state, 0);
    endtask

    // reference: unsigned max of window k over the default-size frame
    function automatic logic [7:0] ref_pool(input logic [NPIX*DW-1:0] f, input int k);
        int r = k / 7;
        int c = k % 7;
        logic [7:0] m = '0;
        logic [7:0] v;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                v = f[((2 * r + dr) * IW + 2 * c + dc) * DW +: DW];
                if (v > m) m = v;
            end
        end
        return m;
    endfunction

    task automatic fill_exp();
        exp_q.delete();
        for (int k = 0; k < NOUT; k++) exp_q.push_back(ref_pool(frame, k));
    endtask

    task automatic load_ramp();
        for (int p = 0; p < NPIX; p++) frame[p*DW +: DW] = 8'(p % 256);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_valid_not_yet", out_valid, 0);
    endtask

    // Drives out_ready and scores every presented value against exp_q.
    // abort_at / start_at / rst_at < 0 disable that disturbance.
    task automatic stream(input bit bp, input int abort_at, input int start_at, input int rst_at);
        int cyc = 0;
        bit start_sent = 0;
        n_acc    = 0;
        acc_cyc  = -1;
        done_cyc = -1;
        while (cyc < 400) begin
            @(negedge clk);
            start     = 1'b0;
            out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (cyc == 0) check("first_valid_latency", out_valid, 1);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (out_valid) begin
                if (abort_at >= 0 && n_acc == abort_at) begin
                    abort = 1'b1;
                    break;
                end
                if (rst_at >= 0 && n_acc == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_idle_zero("midframe_reset");
                    break;
                end
                if (start_at >= 0 && n_acc == start_at && !start_sent) begin
                    start      = 1'b1;
                    frame      = '0;
                    start_sent = 1;
                end
                if (exp_q.size() == 0) begin
                    check("extra_value", n_acc, NOUT - 1);
                end else begin
                    check("data", out_data, exp_q[0]);
                    check("idx",  out_idx,  n_acc);
                    check("last", out_last, (n_acc == NOUT - 1));
                    if (out_ready) begin
                        got_data[n_acc] = out_data;
                        void'(exp_q.pop_front());
                        n_acc++;
                        acc_cyc = cyc;
                    end
                end
            end else if (!bp || cyc > 0) begin
                check("valid_held", out_valid, 1);
            end
            cyc++;
        end
        if (abort_at < 0 && rst_at < 0) begin
            check("done_seen", (done_cyc >= 0), 1);
            if (done_cyc >= 0) begin
                check("done_after_last", done_cyc, acc_cyc + 1);
                check("done_busy_low",   busy,      0);
                check("done_valid_low",  out_valid, 0);
                check("value_count",     n_acc,     NOUT);
                @(negedge clk);
                check("done_one_cycle", done, 0);
            end
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        check("reset_busy_s", busy_s, 0);
        check("reset_busy_m", busy_m, 0);
        rst_n = 1'b1;

        // ramp frame, full throughput
        load_ramp();
        fill_exp();
        pulse_start();
        stream(0, -1, -1, -1);
        check("ramp_win0",  got_data[0],  8'd15);
        check("ramp_win1",  got_data[1],  8'd17);
        check("ramp_win48", got_data[48], 8'd195);

        // backpressure 1,0,0,1
        fill_exp();
        pulse_start();
        stream(1, -1, -1, -1);
        out_ready = 1'b1;

        // abort at idx 10, then a clean frame
        fill_exp();
        pulse_start();
        stream(0, 10, -1, -1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid_low", out_valid, 0);
        check("abort_busy_low",  busy,      0);
        check("abort_last_low",  out_last,  0);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", done, 0);
            @(negedge clk);
        end
        fill_exp();
        pulse_start();
        stream(0, -1, -1, -1);
        check("after_abort_win0", got_data[0], 8'd15);

        // start during RUN (with frame zeroed) must not disturb the sequence
        fill_exp();
        pulse_start();
        stream(0, -1, 5, -1);
        load_ramp();

        // asynchronous reset mid-frame, then a normal frame
        fill_exp();
        pulse_start();
        stream(0, -1, -1, 20);
        @(negedge clk);
        check("reset_hold_no_done", done, 0);
        rst_n = 1'b1;
        fill_exp();
        pulse_start();
        stream(0, -1, -1, -1);

        // negative pixel pattern: unsigned instance, then signed / ReLU instances
        frame_s[0*DW  +: DW] = 8'h80;
        frame_s[1*DW  +: DW] = 8'hF0;
        frame_s[14*DW +: DW] = 8'hFF;
        frame_s[15*DW +: DW] = 8'h90;
        frame = frame_s;
        fill_exp();
        pulse_start();
        stream(0, -1, -1, -1);
        check("unsigned_win0", got_data[0], 8'hFF);
        check("unsigned_win1", got_data[1], 8'h00);

        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        @(negedge clk);
        check("signed_valid",   valid_s, 1);
        check("signed_idx0",    idx_s,   0);
        check("signed_win0",    data_s,  8'hFF);
        check("relu_valid",     valid_r, 1);
        check("relu_win0",      data_r,  8'h00);
        @(negedge clk);
        check("signed_idx1",    idx_s,   1);
        check("signed_win1",    data_s,  8'h00);
        check("relu_win1",      data_r,  8'h00);
        for (int i = 0; i < 100; i++) begin
            if (done_s) break;
            @(negedge clk);
        end
        check("signed_done", done_s, 1);
        check("relu_done",   done_r, 1);

        // 5x3: trailing column and row dropped
        for (int p = 0; p < 15; p++) frame_m[p*DW +: DW] = ((p % 5 == 4) || (p / 5 == 2)) ? 8'hFF : 8'h01;
        @(negedge clk);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        check("small_busy", busy_m, 1);
        @(negedge clk);
        check("small_valid0", valid_m, 1);
        check("small_data0",  data_m,  8'h01);
        check("small_idx0",   idx_m,   0);
        check("small_last0",  last_m,  0);
        @(negedge clk);
        check("small_data1",  data_m,  8'h01);
        check("small_idx1",   idx_m,   1);
        check("small_last1",  last_m,  1);
        @(negedge clk);
        check("small_done",   done_m,  1);
        check("small_idle",   busy_m,  0);
        check("small_vlow",   valid_m, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
